// File: rtl/cpu10_pkg.sv
// rtl/cpu10_pkg.sv - shared widths and scheduler state encoding for the 10-bit CPU
package cpu10_pkg;

  localparam int CPU_DW = 10;
  localparam int CPU_AW = 10;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DATA  = 2'd1,
    S_FETCH = 2'd2,
    S_ADV   = 2'd3
  } sched_state_t;

endpackage

// File: rtl/mem_watchdog.sv
// rtl/mem_watchdog.sv - per-transaction acknowledge watchdog
// expire fires in the cycle whose edge would bring the count to TIMEOUT-1.
module mem_watchdog #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] ABORT_AT = CW'(TIMEOUT - 2);
  localparam logic [CW-1:0] CAP      = CW'(TIMEOUT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != CAP)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire = en && (cnt_q == ABORT_AT);

endmodule

// File: rtl/mem_sched.sv
// rtl/mem_sched.sv - shares one memory port between data access and fetch
// and issues the one-cycle pipeline-advance pulse per step.
module mem_sched
  import cpu10_pkg::*;
#(
  parameter int DW      = CPU_DW,
  parameter int AW      = CPU_AW,
  parameter int TIMEOUT = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_wdata,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output logic [DW-1:0] if_rdata,
  output logic [DW-1:0] d_rdata,
  output logic          pipe_adv,
  output logic          pc_en,
  output logic          err
);

  sched_state_t state_q, state_d;
  logic          pend_if_q, pend_if_d;
  logic          pend_d_q, pend_d_d;
  logic          fetch_done_q, fetch_done_d;
  logic          d_we_lat_q, d_we_lat_d;
  logic [AW-1:0] d_addr_lat_q, d_addr_lat_d;
  logic [DW-1:0] d_wdata_lat_q, d_wdata_lat_d;
  logic [AW-1:0] if_addr_lat_q, if_addr_lat_d;
  logic          mem_req_q, mem_req_d;
  logic          mem_we_q, mem_we_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic [DW-1:0] if_rdata_q, if_rdata_d;
  logic [DW-1:0] d_rdata_q, d_rdata_d;
  logic          pipe_adv_q, pipe_adv_d;
  logic          pc_en_q, pc_en_d;
  logic          err_q, err_d;
  logic          wd_clr, wd_en, wd_expire;

  mem_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
    .clk    (clk),
    .rst_n  (reset_n),
    .clr    (wd_clr),
    .en     (wd_en),
    .expire (wd_expire)
  );

  always_comb begin
    state_d       = state_q;
    pend_if_d     = pend_if_q;
    pend_d_d      = pend_d_q;
    fetch_done_d  = fetch_done_q;
    d_we_lat_d    = d_we_lat_q;
    d_addr_lat_d  = d_addr_lat_q;
    d_wdata_lat_d = d_wdata_lat_q;
    if_addr_lat_d = if_addr_lat_q;
    if_rdata_d    = if_rdata_q;
    d_rdata_d     = d_rdata_q;
    err_d         = err_q;

    case (state_q)
      S_IDLE: begin
        pend_if_d     = if_req;
        pend_d_d      = d_req;
        d_we_lat_d    = d_we;
        d_addr_lat_d  = d_addr;
        d_wdata_lat_d = d_wdata;
        if_addr_lat_d = if_addr;
        fetch_done_d  = 1'b0;
        state_d       = d_req ? S_DATA : (if_req ? S_FETCH : S_ADV);
      end
      S_DATA: begin
        if (mem_ack || wd_expire) begin
          if (mem_ack) begin
            if (!d_we_lat_q) d_rdata_d = mem_rdata;
          end else begin
            d_rdata_d = '0;
            err_d     = 1'b1;
          end
          state_d = pend_if_q ? S_FETCH : S_ADV;
        end
      end
      S_FETCH: begin
        if (mem_ack) begin
          if_rdata_d   = mem_rdata;
          fetch_done_d = 1'b1;
          state_d      = S_ADV;
        end else if (wd_expire) begin
          if_rdata_d = '0;
          err_d      = 1'b1;
          state_d    = S_ADV;
        end
      end
      S_ADV: begin
        pend_if_d    = 1'b0;
        pend_d_d     = 1'b0;
        fetch_done_d = 1'b0;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are a registered view of the state being entered, so they are Moore.
    mem_req_d   = (state_d == S_DATA) || (state_d == S_FETCH);
    mem_we_d    = (state_d == S_DATA) && d_we_lat_d;
    mem_addr_d  = (state_d == S_DATA) ? d_addr_lat_d :
                  (state_d == S_FETCH) ? if_addr_lat_d : '0;
    mem_wdata_d = (state_d == S_DATA) ? d_wdata_lat_d : '0;
    pipe_adv_d  = (state_d == S_ADV);
    pc_en_d     = (state_d == S_ADV) && fetch_done_d;

    wd_clr = ((state_d == S_DATA) && (state_q != S_DATA)) ||
             ((state_d == S_FETCH) && (state_q != S_FETCH));
    wd_en  = ((state_q == S_DATA) || (state_q == S_FETCH)) && !mem_ack;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      pend_if_q     <= 1'b0;
      pend_d_q      <= 1'b0;
      fetch_done_q  <= 1'b0;
      d_we_lat_q    <= 1'b0;
      d_addr_lat_q  <= '0;
      d_wdata_lat_q <= '0;
      if_addr_lat_q <= '0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      if_rdata_q    <= '0;
      d_rdata_q     <= '0;
      pipe_adv_q    <= 1'b0;
      pc_en_q       <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      pend_if_q     <= pend_if_d;
      pend_d_q      <= pend_d_d;
      fetch_done_q  <= fetch_done_d;
      d_we_lat_q    <= d_we_lat_d;
      d_addr_lat_q  <= d_addr_lat_d;
      d_wdata_lat_q <= d_wdata_lat_d;
      if_addr_lat_q <= if_addr_lat_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      if_rdata_q    <= if_rdata_d;
      d_rdata_q     <= d_rdata_d;
      pipe_adv_q    <= pipe_adv_d;
      pc_en_q       <= pc_en_d;
      err_q         <= err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign pipe_adv  = pipe_adv_q;
  assign pc_en     = pc_en_q;
  assign err       = err_q;

endmodule

// File: doc/mem_sched.md
# mem_sched

Memory-access scheduler for the 10-bit pipelined CPU. It shares the single-ported cache/RAM between instruction fetch (IF) and the memory stage (MEM), serving data first and fetch second. It produces the one-cycle pipeline-advance pulse that drives the enable (`cache_Ready`) of every stage register, plus `pc_en`. A watchdog keeps the pipeline from hanging on a lost acknowledge.

## Interface
- `DW`, 10: data width
- `AW`, 10: address width
- `TIMEOUT`, 16: maximum cycles waited for `mem_ack` per transaction (≥2)

Ports:
- `clk`  in  1  clock; all state updates on rising edge
- `reset_n`  in  1  asynchronous, active-low reset
- `if_req`  in  1  IF needs an instruction this step
- `if_addr`  in  AW  fetch address
- `d_req`  in  1  MEM stage needs a data access this step
- `d_we`  in  1  1 = store, 0 = load
- `d_addr`  in  AW  data address
- `d_wdata`  in  DW  store data
- `mem_req`  out  1  transaction request to cache/RAM
- `mem_we`  out  1  write strobe
- `mem_addr`  out  AW  address
- `mem_wdata`  out  DW  write data
- `mem_ack`  in  1  one-cycle completion pulse
- `mem_rdata`  in  DW  read data, valid with `mem_ack`
- `if_rdata`  out  DW  last fetched instruction
- `d_rdata`  out  DW  last loaded data
- `pipe_adv`  out  1  one-cycle pulse: all stage registers capture
- `pc_en`  out  1  one-cycle pulse with `pipe_adv` when a fetch completed this step
- `err`  out  1  sticky timeout flag

## Operation
- **States:** S_IDLE, S_DATA, S_FETCH, S_ADV.
- **S_IDLE:**
  - Latch `if_req` → `pend_if` and `d_req` → `pend_d`; request changes are ignored until the next S_IDLE.
  - If `pend_d` is set → S_DATA; else if `pend_if` is set → S_FETCH; else → S_ADV.
- **S_DATA:**
  - `mem_req`=1, `mem_we`=`d_we`, `mem_addr`/`mem_wdata` taken from the latched `d_*` values.
  - On `mem_ack`: if load, capture `mem_rdata` into `d_rdata`. Next state is S_FETCH if `pend_if` is set, else S_ADV.
- **S_FETCH:**
  - `mem_req`=1, `mem_we`=0, `mem_addr`=latched `if_addr`.
  - On `mem_ack`: capture `mem_rdata` into `if_rdata`, set `fetch_done`, go to S_ADV.
- **S_ADV:**
  - `pipe_adv`=1 and `pc_en`=`fetch_done`.
  - Clear `pend_*` and `fetch_done`, go to S_IDLE.
- **Watchdog:**
  - Counter clears on entry to S_DATA or S_FETCH and increments each cycle without `mem_ack`.
  - When it reaches TIMEOUT-1: set `err` (sticky until reset) and load 0 into the corresponding rdata register. In S_FETCH, `fetch_done` stays 0.
  - The next state is then the same as it would have been on `mem_ack`.
- `mem_ack` in S_IDLE or S_ADV is ignored.

## Timing
- **Registered outputs:** `mem_req`, `mem_we`, `mem_addr`, `mem_wdata`, `pipe_adv`, `pc_en`, `if_rdata`, `d_rdata` and `err` are all registered (Moore).
- **Reset values:** all outputs are 0 and state is S_IDLE. Reset takes effect immediately when `reset_n` falls, including mid-transaction; `mem_req` drops asynchronously.
- **Memory handshake:**
  - `mem_req` and its address/data stay stable until the edge that samples `mem_ack` or the timeout.
  - Data→fetch is back-to-back: `mem_req` stays high and address/`we` change on the ack edge.
- **Step latency**, from the S_IDLE cycle to the `pipe_adv` cycle inclusive, with memory latency L ≥ 1 cycles per access:
  - no request: 2 cycles
  - one access: L+2 cycles
  - both accesses: 2L+2 cycles
- `pipe_adv` is high for exactly one cycle, so the negedge stage registers capture once per step.
- **Watchdog counter:** $clog2(TIMEOUT) bits; it never wraps because it saturates at the abort point.

## Structure
- **Shared package `cpu10_pkg`:** the DW/AW constants and the `sched_state_t` enum (S_IDLE, S_DATA, S_FETCH, S_ADV).
- **Sub-module `mem_watchdog`:** counter with clear/enable inputs and TIMEOUT parameter, producing an `expire` pulse.
- Everything else is a single module.

## Test plan
- **No requests:** `pipe_adv` pulses every 2nd cycle; `pc_en`=0 and `mem_req`=0 throughout.
- **Fetch only:** `if_addr`=0x005, memory acks after 3 cycles with 0x2A1 → `if_rdata`=0x2A1 and `pipe_adv`=`pc_en`=1 one cycle after the ack edge; step latency 5 cycles.
- **Load and fetch together:** `d_addr`=0x100 returns 0x0F0, then `if_addr`=0x006 returns 0x155 → data access first, `mem_req` continuous across the switch, `d_rdata`=0x0F0, `if_rdata`=0x155, `pc_en`=1.
- **Store:** `d_we`=1, `d_addr`=0x3FF, `d_wdata`=0x123 → `mem_we`=1 with those values held until ack; `d_rdata` unchanged.
- **Timeout:** fetch with `mem_ack` never asserted → after 15 cycles in S_FETCH, `err`=1, `if_rdata`=0, `pipe_adv`=1 with `pc_en`=0. `err` stays 1 over the next steps.
- **Reset mid-operation:** drop `reset_n` while in S_DATA → `mem_req` goes to 0 immediately and all outputs go to 0. A late `mem_ack` after release is ignored, and the next step restarts from S_IDLE.
